// File: rtl/sdram_rw_arbiter.sv
// Shares one SDRAM command port between the UART write FIFO drain, the TFT
// read FIFO refill and auto-refresh. Also owns the frame address counters.
module sdram_rw_arbiter #(
    parameter int BURST_LEN = 8,
    parameter int IMG_WORDS = 1000,
    parameter int ADDR_W    = 22,
    parameter int CNT_W     = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              init_done,
    input  logic              ref_tick,
    input  logic [CNT_W-1:0]  wr_level,
    input  logic [CNT_W-1:0]  rd_space,
    input  logic              cmd_ack,
    input  logic              cmd_done,
    output logic              cmd_wr,
    output logic              cmd_rd,
    output logic              cmd_ref,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [CNT_W-1:0]  cmd_len,
    output logic              frame_valid,
    output logic              frame_start,
    output logic              ref_overrun,
    output logic              busy
);

    localparam int PTR_W = $clog2(IMG_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_REF  = 3'd2,
        S_WR   = 3'd3,
        S_RD   = 3'd4,
        S_WAIT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_REF = 2'd0,
        OP_WR  = 2'd1,
        OP_RD  = 2'd2
    } op_t;

    // A burst never crosses the end of the frame, so the last one may be short.
    function automatic logic [CNT_W-1:0] burst_len(input logic [PTR_W-1:0] p);
        int rem;
        rem = IMG_WORDS - int'(p);
        if (rem < BURST_LEN) begin
            return CNT_W'(rem);
        end else begin
            return CNT_W'(BURST_LEN);
        end
    endfunction

    state_t            state_r, state_nx_s;
    op_t               cur_op_r, last_grant_r, grant_op_s;
    logic              grant_s, ack_s, fin_s;
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]    wr_sum_s, rd_sum_s;
    logic [CNT_W-1:0]  wr_len_s, rd_len_s;
    logic              wr_need_s, rd_need_s;
    logic              ref_pend_r, ref_overrun_r, frame_valid_r, frame_start_r;
    logic              cmd_wr_r, cmd_rd_r, cmd_ref_r, busy_r;
    logic [ADDR_W-1:0] cmd_addr_r;
    logic [CNT_W-1:0]  cmd_len_r;

    assign wr_len_s  = burst_len(wr_ptr_r);
    assign rd_len_s  = burst_len(rd_ptr_r);
    assign wr_need_s = (wr_level >= wr_len_s);
    assign rd_need_s = frame_valid_r && (rd_space >= rd_len_s);
    assign wr_sum_s  = {1'b0, wr_ptr_r} + (PTR_W+1)'(wr_len_s);
    assign rd_sum_s  = {1'b0, rd_ptr_r} + (PTR_W+1)'(rd_len_s);

    assign cmd_wr      = cmd_wr_r;
    assign cmd_rd      = cmd_rd_r;
    assign cmd_ref     = cmd_ref_r;
    assign cmd_addr    = cmd_addr_r;
    assign cmd_len     = cmd_len_r;
    assign frame_valid = frame_valid_r;
    assign frame_start = frame_start_r;
    assign ref_overrun = ref_overrun_r;
    assign busy        = busy_r;

    // Next-state decode, grant selection and ack/completion detection.
    always_comb begin
        state_nx_s = state_r;
        grant_s    = 1'b0;
        grant_op_s = OP_REF;
        ack_s      = 1'b0;
        fin_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (init_done) begin
                    state_nx_s = S_ARB;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_ARB: begin
                if (ref_pend_r) begin
                    grant_s    = 1'b1;
                    grant_op_s = OP_REF;
                    state_nx_s = S_REF;
                end else if (wr_need_s && rd_need_s) begin
                    grant_s = 1'b1;
                    if (last_grant_r == OP_WR) begin
                        grant_op_s = OP_RD;
                        state_nx_s = S_RD;
                    end else begin
                        grant_op_s = OP_WR;
                        state_nx_s = S_WR;
                    end
                end else if (wr_need_s) begin
                    grant_s    = 1'b1;
                    grant_op_s = OP_WR;
                    state_nx_s = S_WR;
                end else if (rd_need_s) begin
                    grant_s    = 1'b1;
                    grant_op_s = OP_RD;
                    state_nx_s = S_RD;
                end else begin
                    state_nx_s = S_ARB;
                end
            end
            S_REF, S_WR, S_RD: begin
                if (cmd_ack) begin
                    ack_s = 1'b1;
                    // Same-cycle done is treated as ack immediately followed by done.
                    if (cmd_done) begin
                        fin_s      = 1'b1;
                        state_nx_s = S_ARB;
                    end else begin
                        state_nx_s = S_WAIT;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            S_WAIT: begin
                if (cmd_done) begin
                    fin_s      = 1'b1;
                    state_nx_s = S_ARB;
                end else begin
                    state_nx_s = S_WAIT;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State register and busy flag.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= !((state_nx_s == S_IDLE) || (state_nx_s == S_ARB));
        end
    end

    // Refresh pending and sticky overrun tracking.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ref_pend_r    <= 1'b0;
            ref_overrun_r <= 1'b0;
        end else begin
            ref_pend_r <= ref_tick || (ref_pend_r && !(ack_s && (state_r == S_REF)));
            if (ref_tick && ref_pend_r && !(ack_s && (state_r == S_REF))) begin
                ref_overrun_r <= 1'b1;
            end else begin
                ref_overrun_r <= ref_overrun_r;
            end
        end
    end

    // Command request registers: loaded on grant, dropped on ack.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cmd_wr_r     <= 1'b0;
            cmd_rd_r     <= 1'b0;
            cmd_ref_r    <= 1'b0;
            cmd_addr_r   <= {ADDR_W{1'b0}};
            cmd_len_r    <= {CNT_W{1'b0}};
            cur_op_r     <= OP_REF;
            last_grant_r <= OP_RD;
        end else if (grant_s) begin
            cur_op_r  <= grant_op_s;
            cmd_wr_r  <= (grant_op_s == OP_WR);
            cmd_rd_r  <= (grant_op_s == OP_RD);
            cmd_ref_r <= (grant_op_s == OP_REF);
            case (grant_op_s)
                OP_WR: begin
                    cmd_addr_r <= ADDR_W'(BASE_ADDR) + ADDR_W'(wr_ptr_r);
                    cmd_len_r  <= wr_len_s;
                end
                OP_RD: begin
                    cmd_addr_r <= ADDR_W'(BASE_ADDR) + ADDR_W'(rd_ptr_r);
                    cmd_len_r  <= rd_len_s;
                end
                default: begin
                    cmd_addr_r <= {ADDR_W{1'b0}};
                    cmd_len_r  <= {CNT_W{1'b0}};
                end
            endcase
        end else if (ack_s) begin
            cmd_wr_r  <= 1'b0;
            cmd_rd_r  <= 1'b0;
            cmd_ref_r <= 1'b0;
            if (cur_op_r != OP_REF) begin
                last_grant_r <= cur_op_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end else begin
            cmd_wr_r  <= cmd_wr_r;
            cmd_rd_r  <= cmd_rd_r;
            cmd_ref_r <= cmd_ref_r;
        end
    end

    // Frame pointers, frame_valid and the read-wrap pulse, advanced on completion.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            frame_valid_r <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= 1'b0;
            if (fin_s && (cur_op_r == OP_WR)) begin
                if (wr_sum_s == (PTR_W+1)'(IMG_WORDS)) begin
                    wr_ptr_r      <= {PTR_W{1'b0}};
                    frame_valid_r <= 1'b1;
                end else begin
                    wr_ptr_r <= wr_sum_s[PTR_W-1:0];
                end
            end else if (fin_s && (cur_op_r == OP_RD)) begin
                if (rd_sum_s == (PTR_W+1)'(IMG_WORDS)) begin
                    rd_ptr_r      <= {PTR_W{1'b0}};
                    frame_start_r <= 1'b1;
                end else begin
                    rd_ptr_r <= rd_sum_s[PTR_W-1:0];
                end
            end else begin
                wr_ptr_r <= wr_ptr_r;
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Directed bench for sdram_rw_arbiter: a 1000-word frame instance plus a
// 1004-word instance run in lockstep to exercise the short final burst.
module tb_sdram_rw_arbiter;

    localparam int ADDR_W = 22;
    localparam int CNT_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_done, ref_tick, cmd_ack, cmd_done;
    logic [CNT_W-1:0]  wr_level, rd_space;
    logic              cmd_wr, cmd_rd, cmd_ref, frame_valid, frame_start, ref_overrun, busy;
    logic [ADDR_W-1:0] cmd_addr;
    logic [CNT_W-1:0]  cmd_len;
    logic              b_cmd_wr, b_cmd_rd, b_cmd_ref, b_frame_valid, b_frame_start, b_ref_overrun, b_busy;
    logic [ADDR_W-1:0] b_cmd_addr;
    logic [CNT_W-1:0]  b_cmd_len;

    int checks = 0;
    int errors = 0;
    int fs_cnt = 0;

    always #5 clk = ~clk;

    sdram_rw_arbiter #(.BURST_LEN(8), .IMG_WORDS(1000), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .BASE_ADDR(0)) u_dut (
        .Clk(clk), .Rst(rst), .init_done(init_done), .ref_tick(ref_tick),
        .wr_level(wr_level), .rd_space(rd_space), .cmd_ack(cmd_ack), .cmd_done(cmd_done),
        .cmd_wr(cmd_wr), .cmd_rd(cmd_rd), .cmd_ref(cmd_ref), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .frame_valid(frame_valid), .frame_start(frame_start), .ref_overrun(ref_overrun), .busy(busy)
    );

    sdram_rw_arbiter #(.BURST_LEN(8), .IMG_WORDS(1004), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .BASE_ADDR(0)) u_dut2 (
        .Clk(clk), .Rst(rst), .init_done(init_done), .ref_tick(ref_tick),
        .wr_level(wr_level), .rd_space(rd_space), .cmd_ack(cmd_ack), .cmd_done(cmd_done),
        .cmd_wr(b_cmd_wr), .cmd_rd(b_cmd_rd), .cmd_ref(b_cmd_ref), .cmd_addr(b_cmd_addr), .cmd_len(b_cmd_len),
        .frame_valid(b_frame_valid), .frame_start(b_frame_start), .ref_overrun(b_ref_overrun), .busy(b_busy)
    );

    always @(negedge clk) begin
        if (frame_start) fs_cnt <= fs_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // kind bitmask: 1=wr, 2=rd, 4=ref, 0=nothing within the budget
    task automatic wait_cmd(output int kind);
        int n;
        kind = 0;
        n = 0;
        while (kind == 0 && n < 300) begin
            @(negedge clk);
            n++;
            kind = (cmd_wr ? 1 : 0) + (cmd_rd ? 2 : 0) + (cmd_ref ? 4 : 0);
        end
    endtask

    task automatic do_ack(input bit with_done);
        cmd_ack  = 1'b1;
        cmd_done = with_done;
        @(negedge clk);
        cmd_ack  = 1'b0;
        cmd_done = 1'b0;
        check("req_drop_on_ack", 32'(cmd_wr | cmd_rd | cmd_ref), 0);
    endtask

    task automatic do_done(input int gap);
        repeat (gap) @(negedge clk);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
    endtask

    initial begin
        int k;
        int p;
        rst = 1'b1; init_done = 1'b0; ref_tick = 1'b0; cmd_ack = 1'b0; cmd_done = 1'b0;
        wr_level = 10'd8; rd_space = 10'd0;
        repeat (3) @(negedge clk);
        check("rst_cmd_wr", 32'(cmd_wr), 0);
        check("rst_cmd_rd", 32'(cmd_rd), 0);
        check("rst_cmd_ref", 32'(cmd_ref), 0);
        check("rst_addr", 32'(cmd_addr), 0);
        check("rst_len", 32'(cmd_len), 0);
        check("rst_frame_valid", 32'(frame_valid), 0);
        check("rst_overrun", 32'(ref_overrun), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_no_cmd", 32'(cmd_wr | cmd_rd | cmd_ref), 0);
        check("idle_busy", 32'(busy), 0);
        init_done = 1'b1;

        // Fill one frame: 125 bursts of 8, no reads while frame_valid is low
        for (int i = 0; i < 125; i++) begin
            wait_cmd(k);
            check("fill_kind", k, 1);
            check("fill_addr", 32'(cmd_addr), i * 8);
            check("fill_len", 32'(cmd_len), 8);
            check("fill2_addr", 32'(b_cmd_addr), i * 8);
            if (i == 0) check("fill_busy", 32'(busy), 1);
            if (i == 124) check("fv_before_last", 32'(frame_valid), 0);
            do_ack(1'b0);
            do_done(1);
        end
        check("fv_after_125", 32'(frame_valid), 1);
        check("fv2_after_125", 32'(b_frame_valid), 0);

        wait_cmd(k);
        check("wr126_kind", k, 1);
        check("wr126_addr", 32'(cmd_addr), 0);
        check("wr126_len", 32'(cmd_len), 8);
        check("wr126_b_req", 32'(b_cmd_wr), 1);
        check("wr126_b_addr", 32'(b_cmd_addr), 1000);
        check("wr126_b_len", 32'(b_cmd_len), 4);
        do_ack(1'b0);
        do_done(1);
        check("fv2_after_126", 32'(b_frame_valid), 1);

        // Both requesters ready: round-robin, last grant was a write
        rd_space = 10'd100;
        wait_cmd(k); check("rr0_kind", k, 2); check("rr0_addr", 32'(cmd_addr), 0);
        do_ack(1'b0); do_done(1);
        wait_cmd(k); check("rr1_kind", k, 1); check("rr1_addr", 32'(cmd_addr), 8);
        do_ack(1'b0); do_done(1);
        wait_cmd(k); check("rr2_kind", k, 2); check("rr2_addr", 32'(cmd_addr), 8);
        do_ack(1'b1);
        wait_cmd(k); check("rr3_kind", k, 1); check("rr3_addr", 32'(cmd_addr), 16);
        do_ack(1'b0); do_done(1);
        wait_cmd(k); check("rr4_kind", k, 2); check("rr4_addr", 32'(cmd_addr), 16);
        do_ack(1'b0); do_done(1);

        // Refresh requested during a write wins the next arbitration
        wait_cmd(k); check("wr24_kind", k, 1); check("wr24_addr", 32'(cmd_addr), 24);
        ref_tick = 1'b1;
        @(negedge clk);
        ref_tick = 1'b0;
        check("wr_held_on_tick", 32'(cmd_wr), 1);
        do_ack(1'b0); do_done(2);
        wait_cmd(k); check("ref_first_kind", k, 4);
        check("ref_busy", 32'(busy), 1);
        check("no_overrun_yet", 32'(ref_overrun), 0);
        do_ack(1'b0); do_done(1);
        wait_cmd(k); check("after_ref_kind", k, 2); check("after_ref_addr", 32'(cmd_addr), 24);
        do_ack(1'b0); do_done(1);

        // Two ticks 5 cycles apart in a 50-cycle burst: overrun, single refresh
        wait_cmd(k); check("wr32_kind", k, 1); check("wr32_addr", 32'(cmd_addr), 32);
        do_ack(1'b0);
        repeat (10) @(negedge clk);
        ref_tick = 1'b1; @(negedge clk); ref_tick = 1'b0;
        check("overrun_after_tick1", 32'(ref_overrun), 0);
        repeat (4) @(negedge clk);
        ref_tick = 1'b1; @(negedge clk); ref_tick = 1'b0;
        check("overrun_after_tick2", 32'(ref_overrun), 1);
        do_done(33);
        wait_cmd(k); check("ovr_ref_kind", k, 4);
        do_ack(1'b0); do_done(1);
        wait_cmd(k); check("ovr_next_kind", k, 2); check("ovr_next_addr", 32'(cmd_addr), 32);
        check("overrun_sticky", 32'(ref_overrun), 1);
        wr_level = 10'd0;
        do_ack(1'b0); do_done(1);

        // Finish reading the frame; wrap pulse on the 125th read completion
        p = 40;
        while (p < 1000) begin
            wait_cmd(k);
            check("rd_kind", k, 2);
            check("rd_addr", 32'(cmd_addr), p);
            check("rd_len", 32'(cmd_len), 8);
            check("rd_no_start_yet", fs_cnt, 0);
            do_ack(1'b0);
            do_done(1);
            p = p + 8;
        end
        check("frame_start_pulse", 32'(frame_start), 1);
        @(negedge clk);
        check("frame_start_one_cycle", 32'(frame_start), 0);
        wait_cmd(k);
        check("rd_wrap_kind", k, 2);
        check("rd_wrap_addr", 32'(cmd_addr), 0);
        check("frame_start_count", fs_cnt, 1);

        // Reset while a read waits for ack
        #2 rst = 1'b1;
        #1;
        check("rst_async_cmd_rd", 32'(cmd_rd), 0);
        check("rst_async_fv", 32'(frame_valid), 0);
        check("rst_async_busy", 32'(busy), 0);
        check("rst_async_overrun", 32'(ref_overrun), 0);
        @(negedge clk);
        rst = 1'b0; init_done = 1'b0; wr_level = 10'd8; rd_space = 10'd100;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 32'(cmd_wr | cmd_rd | cmd_ref), 0);
        init_done = 1'b1;
        wait_cmd(k);
        check("post_rst_kind", k, 1);
        check("post_rst_addr", 32'(cmd_addr), 0);
        check("post_rst_fv", 32'(frame_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_rw_arbiter.md
Name: sdram_rw_arbiter

Overview:
Schedules the single SDRAM command port shared by three requesters. The UART-side write FIFO drains image data into SDRAM, the TFT-side read FIFO refills from SDRAM, and the periodic auto-refresh must be serviced. Sits between the two FIFOs and the SDRAM command/timing controller inside the uart-to-sdram-to-tft top level. Also owns the linear frame write/read address counters and the "frame displayable" flag.

Parameters:
BURST_LEN, 8, words per normal write/read burst (power of two, ≥2)
IMG_WORDS, 1000, words per frame (img_h*img_v); address wrap point
ADDR_W, 22, SDRAM linear word address width
CNT_W, 10, width of FIFO level inputs
BASE_ADDR, 0, first word address of the frame buffer

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous active-high reset
init_done  in  1  SDRAM init complete; level
ref_tick  in  1  one-cycle refresh-due pulse from refresh timer
wr_level  in  CNT_W  words currently held in write FIFO
rd_space  in  CNT_W  free words in read FIFO
cmd_ack  in  1  controller accepted the presented command (1 cycle)
cmd_done  in  1  controller finished the accepted command (1 cycle)
cmd_wr  out  1  write burst request
cmd_rd  out  1  read burst request
cmd_ref  out  1  auto-refresh request
cmd_addr  out  ADDR_W  burst start word address
cmd_len  out  CNT_W  burst length in words
frame_valid  out  1  ≥1 full frame written; reads enabled
frame_start  out  1  one-cycle pulse when read address wraps to BASE_ADDR
ref_overrun  out  1  sticky: ref_tick arrived while a refresh was already pending
busy  out  1  high in any state except IDLE/ARB

Behaviour:
- Reset (async, immediate): all outputs 0; wr_ptr=rd_ptr=0; ref_pend=0; state IDLE; last_grant=RD.
- Offsets wr_ptr/rd_ptr count 0..IMG_WORDS-1; cmd_addr = BASE_ADDR + offset.
- Burst length len(p) = min(BURST_LEN, IMG_WORDS-p); a final short burst is legal.
- wr_need = wr_level ≥ len(wr_ptr). rd_need = frame_valid & (rd_space ≥ len(rd_ptr)).
- ref_pend set on ref_tick, cleared on the cmd_ack of a refresh. ref_tick while ref_pend=1 sets ref_overrun (cleared only by Rst).
- States: IDLE, ARB, REF, WR, RD, WAIT.
  - IDLE: stay until init_done=1, then go to ARB.
  - ARB (decision cycle): refresh has highest priority (ref_pend → REF). Else if both wr_need and rd_need, grant the one not in last_grant (round-robin). Else grant the single requester. Else stay. Inputs are sampled in ARB only.
  - REF/WR/RD: cmd_ref/cmd_wr/cmd_rd, cmd_addr and cmd_len are registered on entry and held stable until cmd_ack. On cmd_ack the request drops the same cycle it is sampled, and the state moves to WAIT. last_grant is updated for WR/RD.
  - WAIT: on cmd_done, update pointers and return to ARB. Minimum gap between commands is 1 ARB cycle.
- On write done: wr_ptr += len. If the result equals IMG_WORDS, wr_ptr=0 and frame_valid←1 (stays 1 until Rst).
- On read done: rd_ptr += len. If the result equals IMG_WORDS, rd_ptr=0 and frame_start pulses 1 cycle.
- cmd_ack and cmd_done in the same cycle while in REF/WR/RD: treated as ack followed by done, so the FSM goes directly to ARB and pointers update.
- cmd_ack while no request is asserted is ignored. cmd_done outside WAIT is ignored.
- ref_tick arriving during a WR/RD burst does not abort it; refresh wins at the next ARB.
- init_done falling is ignored after leaving IDLE.
- Worst-case refresh latency is one burst plus 2 cycles.

Test Plan:
- Reset then init_done=1, wr_level=8, rd_space=0 → cmd_wr with cmd_addr=0, cmd_len=8. After ack/done, next write has cmd_addr=8. No cmd_rd is issued while frame_valid=0.
- Fill a full frame (IMG_WORDS=1000, wr_level held ≥8) → 125 write bursts, frame_valid rises on the 125th done, the 126th write uses cmd_addr=0. With IMG_WORDS=1004, the 126th burst has cmd_len=4.
- frame_valid=1, wr_need and rd_need both held → grants alternate WR,RD,WR,RD. ref_tick injected mid-WR → the next command is cmd_ref before any RD.
- Two ref_ticks 5 cycles apart during a 50-cycle burst → ref_overrun=1 (sticky), only one cmd_ref issued.
- Read 1000 words after a valid frame → frame_start pulses exactly once, on the 125th read done. The following read has cmd_addr=BASE_ADDR.
- Assert Rst while cmd_rd is waiting for ack → cmd_rd drops asynchronously. After release, FSM waits in IDLE for init_done, with pointers and frame_valid at 0.
